nes_multi_pad_reader: RTL and testbench
=======================================

# nes_multi_pad_reader

Parametrised NES/SNES-style serial gamepad reader serving `NUM_PADS` controllers on one shared latch/clock pair. It generates a divided, protocol-correct latch pulse and shift clock, and synchronises and samples each pad's serial data line. It publishes debounced-per-scan button vectors with per-scan press/release edge pulses. It sits between the controller port pins and game logic, replacing the single-pad, 8-bit, `SRCLK = CLK` reader.

## Interface
Parameters:
- `NUM_PADS`, 2: number of controllers sharing `SRL`/`SRCLK`.
- `NUM_BITS`, 8: bits per pad. NES uses 8; SNES uses 16.
- `CLK_DIV`, 4: `CLK` cycles per protocol phase. Must be ≥ 4.
- `LATCH_TICKS`, 2: latch-high duration, in phases.
- `AUTO`, 1: 1 = free-running polling; 0 = one scan per `start`.
- `GAP_TICKS`, 16: idle phases between scans when `AUTO=1`.
- `ACTIVE_LOW`, 1: 1 = pad data low means pressed, so the data is inverted.

Ports:
- `CLK` in 1: system clock.
- `reset` in 1: **synchronous, active-low** reset. `reset==0` at a `CLK` edge resets the block.
- `en` in 1: clock enable. While 0, all state, counters and outputs hold.
- `start` in 1: scan request. Used only when `AUTO=0`.
- `D` in `NUM_PADS`: asynchronous serial data, one line per pad.
- `SRL` out 1: latch to all pads.
- `SRCLK` out 1: shift clock to all pads. Idles low.
- `busy` out 1: scan in progress.
- `valid` out 1: one-cycle pulse when `Q` updates.
- `Q` out `NUM_PADS*NUM_BITS`: button `i` of pad `p` is at `Q[p*NUM_BITS+i]`. 1 = pressed. Bit order is A, B, Select, Start, Up, Down, Left, Right, then SNES extras.
- `pressed` out `NUM_PADS*NUM_BITS`: `Q_new & ~Q_old`. Nonzero only while `valid=1`.
- `released` out `NUM_PADS*NUM_BITS`: `~Q_new & Q_old`. Nonzero only while `valid=1`.

## Operation
- `D` passes through a 2-flop synchroniser per pad. Only synchronised values are sampled. The inversion controlled by `ACTIVE_LOW` is applied at sample time.
- State machine `IDLE → LATCH → BIT_LO → BIT_HI → (BIT_LO … ) → DONE → IDLE/GAP`:
  - `IDLE`: `SRL=0`, `SRCLK=0`.
    - `AUTO=0`: leaves on `start=1`.
    - `AUTO=1`: leaves immediately after reset.
  - `LATCH`: `SRL=1` for `LATCH_TICKS` phases.
  - `BIT_LO`: `SRCLK=0` for one phase. On the last cycle of the phase, bit `k` of every pad is shifted into that pad's shadow register.
  - `BIT_HI`: `SRCLK=1` for one phase. Increments `k`. If `k` was `NUM_BITS-1`, the next state is `DONE`; otherwise the next state is `BIT_LO`.
  - `DONE`: one cycle. Copies shadow registers to `Q`, computes `pressed`/`released`, pulses `valid`.
  - `GAP` (`AUTO=1` only): waits `GAP_TICKS` phases, then goes to `LATCH`.
- The phase counter counts 0..`CLK_DIV-1`. It is cleared on entry to `LATCH`, so every phase lasts exactly `CLK_DIV` cycles.
- `start` is ignored while `busy=1`. A `start` held high re-triggers a scan only from `IDLE`.
- `en=0` mid-scan freezes the scan. `SRL`/`SRCLK` hold their levels, and the scan resumes exactly where it stopped.
- Reset at any time, including mid-scan:
  - `SRL=0`, `SRCLK=0`, `busy=0`, `valid=0`.
  - `Q`, `pressed`, `released`, shadow registers and synchronisers are all set to 0.
  - State returns to `IDLE`.
- The first scan after reset compares against `Q=0`, so all held buttons report `pressed`.

## Timing
- All outputs are registered.
- If `start` is accepted at edge `t`:
  - `busy=1` and `SRL=1` from cycle `t+1`.
  - `SRL` stays high for `LATCH_TICKS*CLK_DIV` cycles.
  - Then `NUM_BITS` low/high `SRCLK` pairs follow, each half `CLK_DIV` cycles.
  - `Q` and `valid` update at cycle `t+1+CLK_DIV*(LATCH_TICKS+2*NUM_BITS)`, which is `t+73` with the defaults.
  - `busy` drops in the same cycle.
- Sample point is the last cycle of each `BIT_LO` phase. A pad level change must precede it by ≥ 2 cycles to be captured.
- With `AUTO=1`, consecutive `valid` pulses are `CLK_DIV*(LATCH_TICKS+2*NUM_BITS+GAP_TICKS)+1` cycles apart. That is 137 with the defaults.

## Structure
- Package `nes_pkg` holds:
  - the state enum typedef;
  - button index constants `BTN_A=0 … BTN_RIGHT=7`;
  - the `ACTIVE_LOW` default.
- Sub-module `nes_tick_gen` holds the `CLK_DIV` phase counter with `en` and clear, and outputs a `tick` on the last cycle of each phase.
- Reuse the existing `Synchronizer` for each `D` bit.

## Test plan
- Defaults, `AUTO=0`. Pad model: pad0 presses A+Right (`D` low on bits 0 and 7); pad1 presses none. Pulse `start` at `t`. Required: `valid` at `t+73`, `Q[7:0]=8'h81`, `Q[15:8]=8'h00`, `pressed[7:0]=8'h81`, exactly 8 `SRCLK` rising edges, `SRL` high for 8 cycles.
- Second scan with pad0 changed to A only. Required: `Q[7:0]=8'h01`, `released[7:0]=8'h80`, `pressed` all zero.
- `NUM_BITS=16`, `NUM_PADS=4`, pad3 sends `16'hA5C3`. Required: `Q[63:48]=16'hA5C3`, `valid` at `t+1+4*(2+32)=t+137`.
- `AUTO=1`. Required: first `valid` at cycle 73 after reset release, then every 137 cycles. `start` has no effect.
- Drop `en` for 10 cycles mid-`BIT_HI` of bit 3. Required: outputs frozen, `valid` delayed exactly 10 cycles, `Q` correct.
- Assert `reset=0` during bit 5. Required: next cycle `SRL=0`, `SRCLK=0`, `busy=0`, `Q=0`. After release, a fresh scan returns correct data.

Source files
------------

// File: rtl/nes_pkg.sv
// rtl/nes_pkg.sv - shared types and constants for the NES/SNES pad reader
// Holds the scan state encoding, button bit positions and the default
// data polarity used by nes_multi_pad_reader.
package nes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_BIT_LO,
    ST_BIT_HI,
    ST_DONE,
    ST_GAP
  } nes_state_t;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // Stock pads pull the data line low for a pressed button.
  localparam bit ACTIVE_LOW_DEFAULT = 1'b1;

endpackage

// File: rtl/Synchronizer.sv
// rtl/Synchronizer.sv - two-flop synchroniser for one asynchronous bit
// Ports: CLK clock, reset sync active-low, en hold when 0, d async in,
// q synchronised out.
module Synchronizer (
  input  logic CLK,
  input  logic reset,
  input  logic en,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else if (en) begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nes_tick_gen.sv
// rtl/nes_tick_gen.sv - CLK_DIV phase counter producing an end-of-phase tick
// Ports: CLK clock, reset sync active-low, en count enable, clr holds the
// counter at 0, tick high on the last cycle of each phase.
module nes_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic CLK,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;
  logic          last;

  assign last = (cnt == CW'(CLK_DIV - 1));
  assign tick = en && !clr && last;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      cnt <= '0;
    end else if (en) begin
      if (clr || last) cnt <= '0;
      else             cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/nes_multi_pad_reader.sv
// rtl/nes_multi_pad_reader.sv - serial gamepad reader for NUM_PADS pads
// Ports: CLK clock, reset sync active-low, en global hold, start scan
// request (AUTO=0), D serial data per pad, SRL latch, SRCLK shift clock,
// busy scan in progress, valid one-cycle Q update strobe, Q buttons
// (pad p bit i at p*NUM_BITS+i), pressed/released per-scan edges.
module nes_multi_pad_reader
  import nes_pkg::*;
#(
  parameter int NUM_PADS    = 2,
  parameter int NUM_BITS    = 8,
  parameter int CLK_DIV     = 4,
  parameter int LATCH_TICKS = 2,
  parameter bit AUTO        = 1'b1,
  parameter int GAP_TICKS   = 16,
  parameter bit ACTIVE_LOW  = ACTIVE_LOW_DEFAULT
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         start,
  input  logic [NUM_PADS-1:0]          D,
  output logic                         SRL,
  output logic                         SRCLK,
  output logic                         busy,
  output logic                         valid,
  output logic [NUM_PADS*NUM_BITS-1:0] Q,
  output logic [NUM_PADS*NUM_BITS-1:0] pressed,
  output logic [NUM_PADS*NUM_BITS-1:0] released
);

  localparam int PH_MAX = (LATCH_TICKS > GAP_TICKS) ? LATCH_TICKS : GAP_TICKS;
  localparam int PHW    = ($clog2(PH_MAX) > 0) ? $clog2(PH_MAX) : 1;
  localparam int KW     = ($clog2(NUM_BITS) > 0) ? $clog2(NUM_BITS) : 1;
  localparam int PW     = ($clog2(NUM_PADS) > 0) ? $clog2(NUM_PADS) : 1;

  nes_state_t                         state;
  logic [PHW-1:0]                     ph;
  logic [KW-1:0]                      k;
  logic [NUM_PADS-1:0][NUM_BITS-1:0]  shadow;
  logic [NUM_PADS-1:0]                sync_d;
  logic                               tick;
  logic                               tick_clr;

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_sync
    Synchronizer u_sync (
      .CLK   (CLK),
      .reset (reset),
      .en    (en),
      .d     (D[p]),
      .q     (sync_d[p])
    );
  end

  // Holding the divider at 0 in IDLE and DONE makes the first LATCH and
  // GAP phase start on a clean boundary, so every phase is CLK_DIV long.
  assign tick_clr = (state == ST_IDLE) || (state == ST_DONE);

  nes_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .CLK   (CLK),
    .reset (reset),
    .en    (en),
    .clr   (tick_clr),
    .tick  (tick)
  );

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state    <= ST_IDLE;
      ph       <= '0;
      k        <= '0;
      shadow   <= '0;
      SRL      <= 1'b0;
      SRCLK    <= 1'b0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      Q        <= '0;
      pressed  <= '0;
      released <= '0;
    end else if (en) begin
      valid    <= 1'b0;
      pressed  <= '0;
      released <= '0;
      case (state)
        ST_IDLE: begin
          if (AUTO || start) begin
            state <= ST_LATCH;
            SRL   <= 1'b1;
            busy  <= 1'b1;
            ph    <= '0;
          end
        end
        ST_LATCH: begin
          if (tick) begin
            if (ph == PHW'(LATCH_TICKS - 1)) begin
              state <= ST_BIT_LO;
              SRL   <= 1'b0;
              k     <= '0;
            end else begin
              ph <= ph + PHW'(1);
            end
          end
        end
        ST_BIT_LO: begin
          // Sample at the end of the low phase, just before SRCLK rises
          // and the pads advance to the next bit.
          if (tick) begin
            for (int p = 0; p < NUM_PADS; p++)
              shadow[PW'(p)][k] <= sync_d[PW'(p)] ^ ACTIVE_LOW;
            state <= ST_BIT_HI;
            SRCLK <= 1'b1;
          end
        end
        ST_BIT_HI: begin
          if (tick) begin
            SRCLK <= 1'b0;
            if (k == KW'(NUM_BITS - 1)) begin
              // Q, edges and valid become visible during the DONE cycle.
              state    <= ST_DONE;
              Q        <= shadow;
              pressed  <= shadow & ~Q;
              released <= ~shadow & Q;
              valid    <= 1'b1;
              busy     <= 1'b0;
            end else begin
              k     <= k + KW'(1);
              state <= ST_BIT_LO;
            end
          end
        end
        ST_DONE: begin
          ph    <= '0;
          state <= AUTO ? ST_GAP : ST_IDLE;
        end
        ST_GAP: begin
          if (tick) begin
            if (ph == PHW'(GAP_TICKS - 1)) begin
              state <= ST_LATCH;
              SRL   <= 1'b1;
              busy  <= 1'b1;
              ph    <= '0;
            end else begin
              ph <= ph + PHW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nes_multi_pad_reader.sv
// tb/tb_nes_multi_pad_reader.sv - self-checking bench for nes_multi_pad_reader
module tb_nes_multi_pad_reader;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Three instances: 0 = defaults AUTO=0, 1 = 4 pads x 16 bits AUTO=0,
  // 2 = defaults free-running.
  logic reset0 = 1'b0, rstn = 1'b0, en0 = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [1:0] d0, d2;
  logic [3:0] d1;
  logic srl0, srclk0, busy0, v0, srl1, srclk1, busy1, v1, srl2, srclk2, busy2, v2;
  logic [15:0] q0, p0, r0, q2, p2, r2;
  logic [63:0] q1, p1, r1;

  nes_multi_pad_reader #(.AUTO(1'b0)) dut0 (
    .CLK(CLK), .reset(reset0), .en(en0), .start(start0), .D(d0),
    .SRL(srl0), .SRCLK(srclk0), .busy(busy0), .valid(v0),
    .Q(q0), .pressed(p0), .released(r0));

  nes_multi_pad_reader #(.NUM_PADS(4), .NUM_BITS(16), .AUTO(1'b0)) dut1 (
    .CLK(CLK), .reset(rstn), .en(1'b1), .start(start1), .D(d1),
    .SRL(srl1), .SRCLK(srclk1), .busy(busy1), .valid(v1),
    .Q(q1), .pressed(p1), .released(r1));

  nes_multi_pad_reader dut2 (
    .CLK(CLK), .reset(rstn), .en(1'b1), .start(start2), .D(d2),
    .SRL(srl2), .SRCLK(srclk2), .busy(busy2), .valid(v2),
    .Q(q2), .pressed(p2), .released(r2));

  // Pad model: latch resets the bit pointer, each SRCLK rise advances it,
  // the line is low for a held button.
  logic [63:0] btn [3];
  int idx [3];
  initial begin
    idx[0] = 0; idx[1] = 0; idx[2] = 0;
    btn[0] = 64'h0081;
    btn[1] = {16'hA5C3, 16'hFFFF, 16'h0000, 16'h1234};
    btn[2] = 64'h0F5A;
  end
  always @(posedge srl0)   idx[0] = 0;
  always @(posedge srclk0) idx[0]++;
  always @(posedge srl1)   idx[1] = 0;
  always @(posedge srclk1) idx[1]++;
  always @(posedge srl2)   idx[2] = 0;
  always @(posedge srclk2) idx[2]++;

  function automatic logic [3:0] pad_d(input logic [63:0] b, input int nb, input int i);
    logic [3:0] r;
    for (int p = 0; p < 4; p++) r[p] = (i < nb) ? ~b[p*nb+i] : 1'b0;
    return r;
  endfunction

  logic [3:0] dd0, dd2;
  assign dd0 = pad_d(btn[0], 8, idx[0]);
  assign dd2 = pad_d(btn[2], 8, idx[2]);
  assign d1  = pad_d(btn[1], 16, idx[1]);
  assign d0  = dd0[1:0];
  assign d2  = dd2[1:0];

  // Behavioural model: for each instance, the cycle at which valid is due,
  // and the last published button vector.
  int          exp_at [3];
  logic [63:0] q_old  [3];
  bit          auto_m [3];
  bit          chk_on = 1'b0;
  logic [63:0] a_q [3], a_p [3], a_r [3];
  logic        a_v [3];
  assign a_q[0] = {48'b0, q0}; assign a_p[0] = {48'b0, p0}; assign a_r[0] = {48'b0, r0};
  assign a_q[1] = q1;          assign a_p[1] = p1;          assign a_r[1] = r1;
  assign a_q[2] = {48'b0, q2}; assign a_p[2] = {48'b0, p2}; assign a_r[2] = {48'b0, r2};
  assign a_v[0] = v0; assign a_v[1] = v1; assign a_v[2] = v2;

  initial begin
    for (int d = 0; d < 3; d++) begin exp_at[d] = -1; q_old[d] = '0; end
    auto_m[0] = 1'b0; auto_m[1] = 1'b0; auto_m[2] = 1'b1;
  end

  logic [63:0] e_p, e_r;
  bit          e_v;
  always @(negedge CLK) begin
    if (chk_on) begin
      for (int d = 0; d < 3; d++) begin
        e_v = (cyc == exp_at[d]);
        e_p = '0;
        e_r = '0;
        if (e_v) begin
          e_p      = btn[d] & ~q_old[d];
          e_r      = ~btn[d] & q_old[d];
          q_old[d] = btn[d];
          // Free-running: latch + bits + gap phases, plus the DONE cycle.
          exp_at[d] = auto_m[d] ? exp_at[d] + 4*(2 + 16 + 16) + 1 : -1;
        end
        chk($sformatf("valid%0d", d), {63'b0, a_v[d]}, {63'b0, e_v});
        chk($sformatf("Q%0d", d), a_q[d], q_old[d]);
        chk($sformatf("pressed%0d", d), a_p[d], e_p);
        chk($sformatf("released%0d", d), a_r[d], e_r);
      end
    end
  end

  // Protocol observers for instance 0 and valid pulse times of instance 2.
  int srl_hi = 0, rises = 0, nv2 = 0, first_v2 = -1, second_v2 = -1;
  logic srclk0_prev = 1'b0;
  always @(negedge CLK) begin
    if (srl0) srl_hi++;
    if (srclk0 && !srclk0_prev) rises++;
    srclk0_prev = srclk0;
    if (chk_on && v2) begin
      nv2++;
      if (nv2 == 1) first_v2 = cyc;
      if (nv2 == 2) second_v2 = cyc;
    end
  end

  task automatic go_to(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  // Issued at a falling edge; returns the rising edge that accepts start.
  task automatic start_dut0(output int t);
    start0 = 1'b1;
    t = cyc + 1;
    @(negedge CLK);
    start0 = 1'b0;
  endtask

  int t, r;
  initial begin
    go_to(3);
    chk("rst_srl", {63'b0, srl0}, 64'd0);
    chk("rst_srclk", {63'b0, srclk0}, 64'd0);
    chk("rst_busy", {63'b0, busy0}, 64'd0);
    chk("rst_valid", {63'b0, v0}, 64'd0);
    chk("rst_q", {48'b0, q0}, 64'd0);
    reset0 = 1'b1;
    rstn   = 1'b1;
    r = cyc + 1;
    exp_at[2] = r + 72;
    chk_on = 1'b1;

    // Scan 1: pad0 A+Right, pad1 idle; dut1 started on the same edge.
    go_to(5);
    srl_hi = 0;
    rises  = 0;
    start1 = 1'b1;
    start0 = 1'b1;
    t = cyc + 1;
    exp_at[0] = t + 4*(2 + 2*8);
    exp_at[1] = t + 4*(2 + 2*16);
    @(negedge CLK);
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b1;
    go_to(t + 72);
    chk("s1_valid", {63'b0, v0}, 64'd1);
    chk("s1_q_pad0", {56'b0, q0[7:0]}, 64'h81);
    chk("s1_q_pad1", {56'b0, q0[15:8]}, 64'h00);
    chk("s1_pressed", {56'b0, p0[7:0]}, 64'h81);
    chk("s1_srclk_rises", 64'(rises), 64'd8);
    chk("s1_srl_cycles", 64'(srl_hi), 64'd8);
    start2 = 1'b0;
    go_to(t + 136);
    chk("w16_valid", {63'b0, v1}, 64'd1);
    chk("w16_q_pad3", {48'b0, q1[63:48]}, 64'hA5C3);

    // Scan 2: A only; start held through the scan must not retrigger.
    @(negedge CLK);
    btn[0] = 64'h0001;
    start0 = 1'b1;
    t = cyc + 1;
    exp_at[0] = t + 72;
    repeat (20) @(negedge CLK);
    start0 = 1'b0;
    go_to(t + 72);
    chk("s2_q", {56'b0, q0[7:0]}, 64'h01);
    chk("s2_released", {56'b0, r0[7:0]}, 64'h80);
    chk("s2_pressed", {48'b0, p0}, 64'h0);

    // Enable freeze: 10 edges held during the high phase of bit 3.
    @(negedge CLK);
    btn[0] = 64'h0081;
    start_dut0(t);
    exp_at[0] = t + 72 + 10;
    go_to(t + 37);
    en0 = 1'b0;
    go_to(t + 42);
    chk("frz_srclk", {63'b0, srclk0}, 64'd1);
    chk("frz_srl", {63'b0, srl0}, 64'd0);
    chk("frz_busy", {63'b0, busy0}, 64'd1);
    go_to(t + 47);
    en0 = 1'b1;
    go_to(t + 72);
    chk("frz_no_early_valid", {63'b0, v0}, 64'd0);
    go_to(t + 82);
    chk("frz_valid", {63'b0, v0}, 64'd1);
    chk("frz_pressed", {56'b0, p0[7:0]}, 64'h80);

    // Reset during bit 5, then a fresh scan sees every held button pressed.
    @(negedge CLK);
    start_dut0(t);
    exp_at[0] = t + 72;
    go_to(t + 49);
    reset0 = 1'b0;
    @(posedge CLK);
    #1;
    q_old[0]  = '0;
    exp_at[0] = -1;
    reset0    = 1'b1;
    @(negedge CLK);
    chk("mrst_srl", {63'b0, srl0}, 64'd0);
    chk("mrst_srclk", {63'b0, srclk0}, 64'd0);
    chk("mrst_busy", {63'b0, busy0}, 64'd0);
    chk("mrst_q", {48'b0, q0}, 64'd0);
    @(negedge CLK);
    start_dut0(t);
    exp_at[0] = t + 72;
    go_to(t + 72);
    chk("post_rst_q", {48'b0, q0}, 64'h0081);
    chk("post_rst_pressed", {48'b0, p0}, 64'h0081);

    chk("auto_first", 64'(first_v2), 64'(r + 72));
    chk("auto_second", 64'(second_v2), 64'(r + 72 + 137));
    go_to(cyc + 5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
